// File: rtl/wb_slave_pkg.sv
// Shared Wishbone slave definitions: bus field widths and FSM state encodings.
package wb_slave_pkg;

    localparam int ADR_MSB  = 31;
    localparam int DATA_MSB = 31;
    localparam int SEL_MSB  = (DATA_MSB + 1) / 8 - 1;
    localparam int TAG_MSB  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wb_slave_ram.sv
// Word storage for wb_slave: per-lane byte-enable write, registered read, per-word tag array.
module wb_slave_ram
    import wb_slave_pkg::*;
#(
    parameter int MEM_WORDS = 16,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  addr,
    input  logic [SEL_MSB:0]  be,
    input  logic [DATA_MSB:0] wr_data,
    input  logic [TAG_MSB:0]  wr_tag,
    output logic [DATA_MSB:0] rd_data,
    output logic [TAG_MSB:0]  rd_tag
);

    // One narrow array per byte lane so each lane maps onto its own write enable.
    generate
        for (genvar gi = 0; gi <= SEL_MSB; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    lane_mem[addr] <= wr_data[8*gi +: 8];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_rd_reg <= '0;
                end else if (rd_en) begin
                    lane_rd_reg <= lane_mem[addr];
                end
            end

            assign rd_data[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

    logic [TAG_MSB:0] tag_mem [MEM_WORDS];
    logic [TAG_MSB:0] tag_rd_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[addr] <= wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_rd_reg <= '0;
        end else if (rd_en) begin
            tag_rd_reg <= tag_mem[addr];
        end
    end

    assign rd_tag = tag_rd_reg;

endmodule

// File: rtl/wb_slave.sv
// Wishbone classic slave with byte-lane RAM; WB_SLAVE_WAIT_EN adds WAIT_CYCLES wait states before ack.
module wb_slave
    import wb_slave_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_WORDS   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADR_MSB:0]  adr_i,
    input  logic [SEL_MSB:0]  sel_i,
    input  logic [DATA_MSB:0] dat_i,
    input  logic [TAG_MSB:0]  tga_i,
    input  logic [TAG_MSB:0]  tgd_i,
    input  logic [TAG_MSB:0]  tgc_i,
    input  logic              we_i,
    input  logic              stb_i,
    input  logic              cyc_i,
    output logic [DATA_MSB:0] dat_o,
    output logic [TAG_MSB:0]  tgd_o,
    output logic              ack_o
);

    localparam int IDX_W = idx_width(MEM_WORDS);

    wb_state_e        state_reg, state_next;
    logic             req;
    logic             enter_ack;
    logic [TAG_MSB:0] tag_cap;
    logic             ack_reg;
    logic             ack_we_reg;
    logic [TAG_MSB:0] tag_ack_reg;
    logic [IDX_W-1:0] word_idx;
    logic [TAG_MSB:0] ram_tag;

    assign req      = cyc_i & stb_i;
    assign word_idx = adr_i[IDX_W+1:2];

`ifdef WB_SLAVE_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [TAG_MSB:0] tgc_hold_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg      <= '0;
            tgc_hold_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (state_reg == ST_IDLE && req) begin
                tgc_hold_reg <= tgc_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Master withdrawing the strobe mid-wait abandons the transfer silently.
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_W'(WAIT_CYCLES - 1)) begin
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The cycle tag belongs to the accepting edge, which precedes ACK entry when waiting.
    assign tag_cap = (state_reg == ST_IDLE) ? tgc_i : tgc_hold_reg;
`else
    logic unused_cfg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign tag_cap    = tgc_i;
    assign unused_cfg = (WAIT_CYCLES != 0);
`endif

    assign enter_ack = (state_next == ST_ACK) && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            ack_reg     <= 1'b0;
            ack_we_reg  <= 1'b0;
            tag_ack_reg <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= (state_next == ST_ACK);
            if (enter_ack) begin
                ack_we_reg  <= we_i;
                tag_ack_reg <= tag_cap;
            end
        end
    end

    wb_slave_ram #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (enter_ack & we_i),
        .rd_en   (enter_ack & ~we_i),
        .addr    (word_idx),
        .be      (sel_i),
        .wr_data (dat_i),
        .wr_tag  (tgd_i),
        .rd_data (dat_o),
        .rd_tag  (ram_tag)
    );

    // Writes echo the cycle tag; reads return the tag stored with the word.
    assign tgd_o = ack_we_reg ? tag_ack_reg : ram_tag;
    assign ack_o = ack_reg;

    logic unused_bits;
    assign unused_bits = ^{tga_i, adr_i[ADR_MSB:IDX_W+2], adr_i[1:0]};

endmodule

// File: tb/tb_wb_slave.sv
// Directed bench for wb_slave; covers the WB_SLAVE_WAIT_EN build when that macro is defined.
module tb_wb_slave;
    import wb_slave_pkg::*;

    localparam int W_CYC = 2;
`ifdef WB_SLAVE_WAIT_EN
    localparam int EFF_W = W_CYC;
`else
    localparam int EFF_W = 0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [ADR_MSB:0]  adr_i;
    logic [SEL_MSB:0]  sel_i;
    logic [DATA_MSB:0] dat_i;
    logic [TAG_MSB:0]  tga_i, tgd_i, tgc_i;
    logic              we_i, stb_i, cyc_i;
    logic [DATA_MSB:0] dat_o;
    logic [TAG_MSB:0]  tgd_o;
    logic              ack_o;

    wb_slave #(.WAIT_CYCLES(W_CYC), .MEM_WORDS(16)) dut (
        .clk_i (clk_i), .rst_i (rst_i), .adr_i (adr_i), .sel_i (sel_i),
        .dat_i (dat_i), .tga_i (tga_i), .tgd_i (tgd_i), .tgc_i (tgc_i),
        .we_i  (we_i),  .stb_i (stb_i), .cyc_i (cyc_i),
        .dat_o (dat_o), .tgd_o (tgd_o), .ack_o (ack_o)
    );

    always #5 clk_i = ~clk_i;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [3:0] tgc, input logic [3:0] tgd,
                        output logic [31:0] rdat, output logic [3:0] rtag, output int lat);
        @(negedge clk_i);
        we_i = we; adr_i = adr; sel_i = sel; dat_i = dat; tgc_i = tgc; tgd_i = tgd;
        tga_i = adr[3:0]; cyc_i = 1'b1; stb_i = 1'b1;
        lat = 0; rdat = '0; rtag = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            lat++;
            if (ack_o) begin
                rdat = dat_o;
                rtag = tgd_o;
                break;
            end
        end
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        $display("xfer we=%0b adr=0x%08h sel=0x%h dat=0x%08h -> dat_o=0x%08h tgd_o=0x%h lat=%0d",
                 we, adr, sel, dat, rdat, rtag, lat);
        @(posedge clk_i); #1;
        chk("ack_single", {31'd0, ack_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    logic [31:0] rd;
    logic [3:0]  rt;
    int          lat;
    int          n;

    initial begin
        rst_i = 1'b1; adr_i = '0; sel_i = '0; dat_i = '0; tga_i = '0; tgd_i = '0; tgc_i = '0;
        we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_tgd", {28'd0, tgd_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Full-word write then read back, with latency and tag behaviour.
        xfer(1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 4'h3, 4'hA, rd, rt, lat);
        chk("wr_lat", lat, EFF_W + 1);
        chk("wr_tgd_is_tgc", {28'd0, rt}, 32'h3);
        xfer(1'b0, 32'h04, 4'hF, 32'h0, 4'h5, 4'h0, rd, rt, lat);
        chk("rd_lat", lat, EFF_W + 1);
        chk("rd_dat", rd, 32'hDEADBEEF);
        chk("rd_tgd_stored", {28'd0, rt}, 32'hA);

        // Partial byte-lane write merges into the existing word.
        xfer(1'b1, 32'h08, 4'hF, 32'h11223344, 4'h0, 4'h1, rd, rt, lat);
        xfer(1'b1, 32'h08, 4'h5, 32'hAABBCCDD, 4'h0, 4'h2, rd, rt, lat);
        xfer(1'b0, 32'h08, 4'hF, 32'h0, 4'h0, 4'h0, rd, rt, lat);
        chk("bytelane_dat", rd, 32'h11BB33DD);
        chk("bytelane_tgd", {28'd0, rt}, 32'h2);
        xfer(1'b0, 32'h08, 4'h0, 32'h0, 4'h0, 4'h0, rd, rt, lat);
        chk("rd_sel0_full", rd, 32'h11BB33DD);

        // Address aliasing: upper bits and byte offset are ignored.
        xfer(1'b1, 32'h40, 4'hF, 32'h5A5A5A5A, 4'h0, 4'h7, rd, rt, lat);
        xfer(1'b0, 32'h00, 4'hF, 32'h0, 4'h0, 4'h0, rd, rt, lat);
        chk("wrap_dat", rd, 32'h5A5A5A5A);
        chk("wrap_tgd", {28'd0, rt}, 32'h7);
        xfer(1'b0, 32'h43, 4'hF, 32'h0, 4'h0, 4'h0, rd, rt, lat);
        chk("lowbits_dat", rd, 32'h5A5A5A5A);

        // Back-to-back: strobe held high gives one idle cycle between acks.
        @(negedge clk_i);
        we_i = 1'b0; adr_i = 32'h04; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        for (int k = 1; k <= 2 * (EFF_W + 2); k++) begin
            @(posedge clk_i); #1;
            chk("b2b_ack", {31'd0, ack_o}, {31'd0, (k % (EFF_W + 2)) == (EFF_W + 1)});
            if (ack_o) chk("b2b_dat", dat_o, 32'hDEADBEEF);
        end
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0;
        $display("xfer back-to-back read adr=0x00000004 done");
        @(posedge clk_i); #1;

        // Asynchronous reset while ack is high clears outputs at once.
        @(negedge clk_i);
        we_i = 1'b0; adr_i = 32'h08; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!ack_o && n < 20);
        chk("pre_rst_ack", {31'd0, ack_o}, 32'd1);
        chk("pre_rst_dat", dat_o, 32'h11BB33DD);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_ack", {31'd0, ack_o}, 32'd0);
        chk("async_rst_dat", dat_o, 32'd0);
        chk("async_rst_tgd", {28'd0, tgd_o}, 32'd0);
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0; rst_i = 1'b0;
        $display("xfer reset during read ack done");

        // Write request under reset must not reach memory.
        @(negedge clk_i);
        rst_i = 1'b1;
        we_i = 1'b1; adr_i = 32'h08; sel_i = 4'hF; dat_i = 32'hCAFEF00D; cyc_i = 1'b1; stb_i = 1'b1;
        repeat (EFF_W + 2) @(posedge clk_i);
        #1;
        chk("rst_wr_ack", {31'd0, ack_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        $display("xfer write under reset adr=0x00000008 suppressed");
        xfer(1'b0, 32'h08, 4'hF, 32'h0, 4'h0, 4'h0, rd, rt, lat);
        chk("rst_wr_kept", rd, 32'h11BB33DD);

`ifdef WB_SLAVE_WAIT_EN
        // Abort in WAIT: no ack and no write.
        xfer(1'b1, 32'h0C, 4'hF, 32'h01020304, 4'h0, 4'h4, rd, rt, lat);
        @(negedge clk_i);
        we_i = 1'b1; adr_i = 32'h0C; sel_i = 4'hF; dat_i = 32'hFFFFFFFF; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk_i); #1;
        chk("abort_wait_ack", {31'd0, ack_o}, 32'd0);
        @(negedge clk_i);
        stb_i = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            if (ack_o) n++;
        end
        chk("abort_no_ack", n, 0);
        @(negedge clk_i);
        cyc_i = 1'b0; we_i = 1'b0;
        $display("xfer aborted write adr=0x0000000c");
        xfer(1'b0, 32'h0C, 4'hF, 32'h0, 4'h0, 4'h0, rd, rt, lat);
        chk("abort_kept", rd, 32'h01020304);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_slave.md
WB_SLAVE -- requirements
Module: wb_slave

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before ack_o (used only when WB_SLAVE_WAIT_EN is defined).
REQ-002 SHALL have parameter MEM_WORDS, default 16, meaning storage depth in DATA_MSB+1-bit words (power of two).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 adr_i  input  ADR_MSB+1  byte address from master.
REQ-006 sel_i  input  SEL_MSB+1  byte lane selects.
REQ-007 dat_i  input  DATA_MSB+1  write data.
REQ-008 tga_i, tgd_i, tgc_i  input  TAG_MSB+1 each  address, data and cycle tags.
REQ-009 we_i, stb_i, cyc_i  input  1 each  write enable, strobe, cycle.
REQ-010 dat_o  output  DATA_MSB+1  read data, registered.
REQ-011 tgd_o  output  TAG_MSB+1  data tag, registered.
REQ-012 ack_o  output  1  transfer acknowledge, registered.

Function
REQ-013 Transfer request = cyc_i & stb_i sampled at a rising edge.
REQ-014 FSM states IDLE, WAIT, ACK; IDLE->ACK on request (macro absent or WAIT_CYCLES=0); IDLE->WAIT on request otherwise; WAIT->ACK when wait counter reaches WAIT_CYCLES-1; ACK->IDLE unconditionally.
REQ-015 ack_o SHALL be high exactly during ACK state, for exactly one cycle per transfer.
REQ-016 Minimum latency: ack_o high in the cycle after the request edge (macro absent); WAIT_CYCLES additional cycles with macro present.
REQ-017 Word index = adr_i[log2(MEM_WORDS)+1:2]; upper address bits ignored (aliasing wrap), adr_i[1:0] ignored.
REQ-018 Write (we_i=1): on the ACK-entry edge, each byte lane n with sel_i[n]=1 SHALL be updated from dat_i; unselected lanes unchanged.
REQ-019 Read (we_i=0): dat_o SHALL hold the full indexed word, valid while ack_o=1; sel_i does not mask read data.
REQ-020 tgd_o SHALL equal tgc_i captured at request acceptance, valid while ack_o=1; on writes, tgd_i is stored per word and returned on tgd_o for subsequent reads of that word instead.
REQ-021 Back-to-back: stb_i held high after ACK SHALL start a new transfer from IDLE, giving one idle cycle between acks.
REQ-022 Abort: cyc_i or stb_i low during WAIT SHALL return FSM to IDLE, no write, no ack.
REQ-023 adr_i, we_i, sel_i, dat_i SHALL be resampled on the ACK-entry edge; master must hold them stable while stb_i high.

Reset
REQ-024 rst_i high SHALL immediately force IDLE, ack_o=0, dat_o=0, tgd_o=0, wait counter=0.
REQ-025 Memory contents SHALL NOT be reset; reset mid-transfer SHALL suppress the pending write and ack.

Configuration
REQ-026 Macro WB_SLAVE_WAIT_EN defined: WAIT state and counter compiled in, latency per REQ-016 with WAIT_CYCLES.
REQ-027 Macro WB_SLAVE_WAIT_EN undefined: WAIT state and counter absent, fixed one-cycle ack, WAIT_CYCLES ignored.

Structure
REQ-028 ADR_MSB, DATA_MSB, SEL_MSB, TAG_MSB and FSM state encodings SHALL come from the shared definitions include used by master.
REQ-029 Storage SHALL be sub-module wb_slave_ram (byte-enable write, synchronous read, data+tag arrays); wb_slave holds FSM and bus logic.

Verification
REQ-030 Write 0xDEADBEEF to adr 0x04, sel 0xF, then read adr 0x04 -> dat_o=0xDEADBEEF with ack_o one cycle after request (macro absent).
REQ-031 Write 0x11223344 sel 0xF then 0xAABBCCDD sel 0x5 to adr 0x08, read -> 0x11BB33DD.
REQ-032 Macro present, WAIT_CYCLES=2: request at cycle 0 -> ack_o high only at cycle 3.
REQ-033 Macro present: drop stb_i in WAIT after write request to adr 0x0C -> no ack_o, later read of 0x0C returns prior contents.
REQ-034 Write adr 0x40 (MEM_WORDS=16) data 0x5A5A5A5A, read adr 0x00 -> 0x5A5A5A5A (wrap).
REQ-035 Assert rst_i mid-write -> ack_o=0 immediately, dat_o=0, tgd_o=0, target word unchanged.
